// File: rtl/imem_port_arbiter_pkg.sv
// rtl/imem_port_arbiter_pkg.sv - shared types and port indices for the imem port arbiter
package imem_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN1 = 1'b1
    } state_e;

    localparam int P_FETCH = 0;
    localparam int P_LOAD  = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker with its preference pointer
module rr_arb2
    import imem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic [1:0] gnt_i,
    input  logic       clr_i,
    output logic [1:0] pick_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        pick_o = 2'b00;
        if (req_i[P_FETCH] && (!req_i[P_LOAD] || (ptr_q == 1'(P_FETCH)))) begin
            pick_o[P_FETCH] = 1'b1;
        end else if (req_i[P_LOAD]) begin
            pick_o[P_LOAD] = 1'b1;
        end
    end

    // The pointer names the preferred port: the loser of the last actual grant.
    // A lock release with no grant that cycle hands preference back to fetch.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_i[P_FETCH]) begin
            ptr_d = 1'(P_LOAD);
        end else if (gnt_i[P_LOAD] || clr_i) begin
            ptr_d = 1'(P_FETCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fetch/loader arbiter in front of the single-port instruction sram
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam logic [3:0] MAX_B   = 4'(MAX_BURST);
    localparam logic       LOCK_EN = (MAX_BURST > 1);

    state_e            state_q;
    logic [3:0]        burst_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [1:0] arb_req;
    logic [1:0] pick;
    logic [1:0] gnt;
    logic       own_exit;
    logic       burst_last;

    // Requests are masked while reset is asserted so the grants and sram pins
    // drop together with the registered state.
    assign arb_req = rst_n ? {req1, req0} : 2'b00;

    always_comb begin
        gnt = 2'b00;
        if (state_q == OWN1) begin
            gnt[P_LOAD]  = arb_req[P_LOAD];
            gnt[P_FETCH] = arb_req[P_FETCH] & ~arb_req[P_LOAD];
        end else begin
            gnt = pick;
        end
    end

    assign burst_last = ((burst_q + 4'd1) >= MAX_B);
    assign own_exit   = (state_q == OWN1) && (!req1 || !lock1 || burst_last);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (arb_req),
        .gnt_i  (gnt),
        .clr_i  (own_exit),
        .pick_o (pick)
    );

    assign gnt0 = gnt[P_FETCH];
    assign gnt1 = gnt[P_LOAD];

    always_comb begin
        sram_cs   = gnt0 | gnt1;
        sram_oe   = gnt0 | (gnt1 & ~we1);
        sram_we   = gnt1 & we1;
        sram_addr = '0;
        sram_din  = '0;
        if (gnt1) begin
            sram_addr = addr1;
            sram_din  = wdata1;
        end else if (gnt0) begin
            sram_addr = addr0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            burst_q   <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt1 && lock1 && LOCK_EN) begin
                        state_q <= OWN1;
                        burst_q <= 4'd1;
                    end
                end
                OWN1: begin
                    if (own_exit) begin
                        state_q <= IDLE;
                        burst_q <= 4'd0;
                    end else begin
                        burst_q <= burst_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1 & ~we1;
            if (gnt0) begin
                rdata0_q <= sram_dout;
            end
            if (gnt1 && !we1) begin
                rdata1_q <= sram_dout;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction SRAM between two requesters:
  - port 0: instruction fetch (read-only),
  - port 1: program loader/debug (read/write).
- Sits between the requesters and the sram instance.
- Round-robin arbitration, optional locked bursts, registered read data one cycle after grant.
- Drives the sram cs/oe/we/addr/din pins directly and samples its dout.

Parameters:
- ADDR_W, 32, address width, matching the sram addr port.
- DATA_W, 32, data width, matching sram din/dout.
- MAX_BURST, 4, max consecutive grants to one port under lock; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  fetch request
- addr0  in  ADDR_W  fetch address
- gnt0  out  1  fetch granted this cycle (combinational)
- rvalid0  out  1  rdata0 valid (registered)
- rdata0  out  DATA_W  fetch read data
- req1  in  1  loader request
- we1  in  1  loader write enable (1 = write, 0 = read)
- lock1  in  1  loader asks to keep ownership next cycle
- addr1  in  ADDR_W  loader address
- wdata1  in  DATA_W  loader write data
- gnt1  out  1  loader granted this cycle (combinational)
- rvalid1  out  1  rdata1 valid (registered; reads only)
- rdata1  out  DATA_W  loader read data
- sram_cs  out  1  sram chip select
- sram_oe  out  1  sram output enable
- sram_we  out  1  sram write enable
- sram_addr  out  ADDR_W  sram address
- sram_din  out  DATA_W  sram write data
- sram_dout  in  DATA_W  sram read data (combinational read)

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, rr_ptr = 0, burst_cnt = 0.
  - rvalid0/1 = 0, rdata0/1 = 0.
  - gnt0/1 = 0, sram_cs/oe/we = 0, sram_addr/din = 0.
- States:
  - IDLE: no owner.
  - OWN1: port 1 holds the lock.
  - Port 0 never locks.
- Arbitration in IDLE (combinational):
  - Only one request: that port wins.
  - Both request: winner = rr_ptr (0 means port 0 preferred).
  - After any grant, rr_ptr <= loser index, i.e. the other port is preferred next.
- Lock:
  - Port 1 granted with lock1 = 1 and MAX_BURST > 1 moves IDLE -> OWN1; burst_cnt <= 1.
  - In OWN1 with req1 = 1: port 1 is granted unconditionally; burst_cnt increments.
  - OWN1 -> IDLE when any of: lock1 = 0, req1 = 0, or burst_cnt reaches MAX_BURST. That cycle's grant still completes if req1 = 1.
  - On exit, rr_ptr <= 0, so fetch gets the next contended grant.
  - req1 = 0 in OWN1: no grant that cycle, return to IDLE. Port 0 may be granted that same cycle if it requests.
- Granted cycle, sram drive:
  - sram_cs = 1.
  - sram_addr = winner address.
  - Port 0: sram_oe = 1, sram_we = 0.
  - Port 1: sram_we = we1, sram_oe = ~we1, sram_din = wdata1.
- No grant: sram_cs = oe = we = 0; addr/din hold 0.
- Read latency is 1:
  - A granted read in cycle t gives rdata <= sram_dout at edge t+1 and rvalid = 1 for exactly cycle t+1.
  - Writes produce no rvalid.
  - rdata holds its last value while rvalid = 0.
- A requester not granted must hold req and addr stable until gnt. The arbiter does not queue.
- Back-to-back grants to the same port give rvalid on consecutive cycles. Throughput is 1 access/cycle.
- Starvation bound: fetch waits at most MAX_BURST + 1 cycles.
- Reset mid-burst: all state and outputs clear immediately. An in-flight rvalid is dropped.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 1'b0, OWN1 = 1'b1;
  - port index constants P_FETCH = 0, P_LOAD = 1.
- One natural sub-module: rr_arb2, the 2-way round-robin picker with pointer register.
- Response registers and lock FSM stay in the top module.

Test Plan:
- Reset: rst_n low mid-operation -> all outputs 0 immediately. After release, req0 = 1 with addr0 = 8 -> gnt0 = 1 same cycle, sram_addr = 8. Next cycle rvalid0 = 1 and rdata0 = mem[8].
- Contention: req0 = req1 = 1 held for 4 cycles, no lock -> grants alternate 0,1,0,1 starting with port 0. Each read gives rvalid on the following cycle.
- Write then read: port 1 writes 0xDEADBEEF to addr 12, then port 0 reads addr 12 -> sram_we = 1 on the write cycle, rvalid1 never asserts, rdata0 = 0xDEADBEEF.
- Locked burst with MAX_BURST = 4: req1 = lock1 = 1 and req0 = 1 held -> gnt1 for 4 consecutive cycles, then gnt0 on the 5th cycle.
- Lock release early: lock1 drops after 2 grants -> return to IDLE, and port 0 is granted on the next contended cycle.
- Idle: no requests -> sram_cs = 0 and rvalid0 = rvalid1 = 0 for 10 cycles.
